// File: rtl/issue_select_unit.sv
// rtl/issue_select_unit.sv - round-robin single-FU issue select with fixed-latency wakeup schedule
// Optional perf counters (perf_grant_cnt, perf_conflict_cnt) enabled by defining ISSUE_SELECT_PERF_CNT_EN.
module issue_select_unit #(
    parameter int NUM_SLOTS = 8,
    parameter int PDST_W    = 7,
    parameter int MAX_LAT   = 4,
    parameter int LAT_W     = $clog2(MAX_LAT + 1),
    parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SLOTS-1:0]        slot_request,
    input  logic [NUM_SLOTS-1:0]        slot_writes_rd,
    input  logic [NUM_SLOTS*PDST_W-1:0] slot_pdst,
    input  logic [NUM_SLOTS*LAT_W-1:0]  slot_lat,
    input  logic                        fu_ready,
    input  logic                        kill,
    input  logic                        ext_wb_valid,
    input  logic [PDST_W-1:0]           ext_wb_pdst,
    output logic [NUM_SLOTS-1:0]        slot_grant,
    output logic                        issue_valid,
    output logic [IDX_W-1:0]            issue_slot_idx,
    output logic [PDST_W-1:0]           issue_pdst,
    output logic                        wakeup_0_valid,
    output logic [PDST_W-1:0]           wakeup_0_pdst,
    output logic                        wakeup_1_valid,
    output logic [PDST_W-1:0]           wakeup_1_pdst
`ifdef ISSUE_SELECT_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_grant_cnt,
    output logic [31:0]                 perf_conflict_cnt
`endif
);

    localparam int                 LAT_SPAN  = 1 << LAT_W;
    localparam logic [LAT_W-1:0]   MAX_LAT_V = LAT_W'(MAX_LAT);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SLOTS - 1);

    logic [MAX_LAT-1:0]   sched_valid;
    logic [PDST_W-1:0]    sched_pdst [MAX_LAT];
    logic [LAT_SPAN-1:0]  sched_valid_ext;
    logic [IDX_W-1:0]     rr_ptr;

    logic [NUM_SLOTS-1:0] conflict;
    logic [NUM_SLOTS-1:0] elig;
    logic [NUM_SLOTS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [LAT_W-1:0]     g_lat;
    logic [PDST_W-1:0]    g_pdst;
    logic                 g_wrd;

    // Entry L is the one that will sit at L-1 next cycle, where a new wakeup would land.
    always_comb begin
        sched_valid_ext = '0;
        sched_valid_ext[MAX_LAT-1:0] = sched_valid;
        conflict = '0;
        elig     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            logic [LAT_W-1:0] lat_i;
            lat_i = slot_lat[i*LAT_W +: LAT_W];
            if (slot_writes_rd[i] && (lat_i < MAX_LAT_V)) begin
                conflict[i] = sched_valid_ext[lat_i];
            end
            elig[i] = slot_request[i] & fu_ready & ~kill & reset & ~conflict[i];
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_SLOTS) begin
                j = j - NUM_SLOTS;
            end
            if (!grant_any && elig[IDX_W'(j)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign slot_grant = grant;

    always_comb begin
        g_lat  = '0;
        g_pdst = '0;
        g_wrd  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (grant[i]) begin
                g_lat  = slot_lat[i*LAT_W +: LAT_W];
                g_pdst = slot_pdst[i*PDST_W +: PDST_W];
                g_wrd  = slot_writes_rd[i];
            end
        end
    end

    // A new wakeup overrides the shift into its entry; a flush drops everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sched_valid <= '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                sched_pdst[k] <= '0;
            end
        end else if (kill) begin
            sched_valid <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (grant_any && g_wrd && (g_lat == LAT_W'(k + 1))) begin
                    sched_valid[k] <= 1'b1;
                    sched_pdst[k]  <= g_pdst;
                end else if (k < MAX_LAT - 1) begin
                    sched_valid[k] <= sched_valid[k+1];
                    sched_pdst[k]  <= sched_pdst[k+1];
                end else begin
                    sched_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign wakeup_0_valid = sched_valid[0];
    assign wakeup_0_pdst  = sched_pdst[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr         <= '0;
            issue_valid    <= 1'b0;
            issue_slot_idx <= '0;
            issue_pdst     <= '0;
        end else begin
            issue_valid <= grant_any;
            if (grant_any) begin
                rr_ptr         <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                issue_slot_idx <= grant_idx;
                issue_pdst     <= g_pdst;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wakeup_1_valid <= 1'b0;
            wakeup_1_pdst  <= '0;
        end else begin
            wakeup_1_valid <= ext_wb_valid;
            wakeup_1_pdst  <= ext_wb_pdst;
        end
    end

`ifdef ISSUE_SELECT_PERF_CNT_EN
    logic conflict_stall;
    assign conflict_stall = (|slot_request) & fu_ready & ~kill & ~grant_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (grant_any) begin
                perf_grant_cnt <= perf_grant_cnt + 32'd1;
            end
            if (conflict_stall) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_lat_chk
            a_lat_legal: assert property (@(posedge clk) disable iff (!reset)
                slot_request[gi] |-> ((slot_lat[gi*LAT_W +: LAT_W] != '0) &&
                                      (slot_lat[gi*LAT_W +: LAT_W] <= MAX_LAT_V)));
        end
    endgenerate

endmodule

// File: tb/tb_issue_select_unit.sv
// tb/tb_issue_select_unit.sv - scoreboard bench for issue_select_unit
module tb_issue_select_unit;

    localparam int N  = 8;
    localparam int PW = 7;
    localparam int LW = 3;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    wrd;
    logic [PW-1:0]   pdst_a [N];
    logic [LW-1:0]   lat_a [N];
    logic [N*PW-1:0] slot_pdst;
    logic [N*LW-1:0] slot_lat;
    logic            fu_ready;
    logic            kill;
    logic            ext_v;
    logic [PW-1:0]   ext_p;

    logic [N-1:0]    slot_grant;
    logic            issue_valid;
    logic [IW-1:0]   issue_slot_idx;
    logic [PW-1:0]   issue_pdst;
    logic            wakeup_0_valid;
    logic [PW-1:0]   wakeup_0_pdst;
    logic            wakeup_1_valid;
    logic [PW-1:0]   wakeup_1_pdst;
`ifdef ISSUE_SELECT_PERF_CNT_EN
    logic [31:0]     perf_grant_cnt;
    logic [31:0]     perf_conflict_cnt;
`endif

    always_comb begin
        slot_pdst = '0;
        slot_lat  = '0;
        for (int i = 0; i < N; i++) begin
            slot_pdst[i*PW +: PW] = pdst_a[i];
            slot_lat[i*LW +: LW]  = lat_a[i];
        end
    end

    issue_select_unit dut (
        .clk            (clk),
        .reset          (reset),
        .slot_request   (req),
        .slot_writes_rd (wrd),
        .slot_pdst      (slot_pdst),
        .slot_lat       (slot_lat),
        .fu_ready       (fu_ready),
        .kill           (kill),
        .ext_wb_valid   (ext_v),
        .ext_wb_pdst    (ext_p),
        .slot_grant     (slot_grant),
        .issue_valid    (issue_valid),
        .issue_slot_idx (issue_slot_idx),
        .issue_pdst     (issue_pdst),
        .wakeup_0_valid (wakeup_0_valid),
        .wakeup_0_pdst  (wakeup_0_pdst),
        .wakeup_1_valid (wakeup_1_valid),
        .wakeup_1_pdst  (wakeup_1_pdst)
`ifdef ISSUE_SELECT_PERF_CNT_EN
        ,
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    typedef struct {
        int            kind;
        int            cyc;
        logic [IW-1:0] idx;
        logic [PW-1:0] pdst;
    } ev_t;

    ev_t   sb[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_grants = 0;
    int    exp_conf = 0;
    string kname [3] = '{"issue", "wakeup_0", "wakeup_1"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [PW-1:0] p, input logic [LW-1:0] l, input logic w);
        pdst_a[i] = p;
        lat_a[i]  = l;
        wrd[i]    = w;
    endtask

    // Called at posedge+1 with inputs applied; checks grant, records expected outputs, advances a cycle.
    task automatic step(input logic [N-1:0] exp_g, input string nm);
        int gi;
        #1;
        chk(nm, 32'(slot_grant), 32'(exp_g));
        if (kill) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].kind == 1 && sb[i].cyc > cyc) sb.delete(i);
            end
        end
        if (exp_g != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (exp_g[i]) gi = i;
            sb.push_back('{kind: 0, cyc: cyc + 1, idx: IW'(gi), pdst: pdst_a[gi]});
            if (wrd[gi]) sb.push_back('{kind: 1, cyc: cyc + int'(lat_a[gi]), idx: '0, pdst: pdst_a[gi]});
            exp_grants++;
        end else if (req != '0 && fu_ready && !kill) begin
            exp_conf++;
        end
        if (ext_v) sb.push_back('{kind: 2, cyc: cyc + 1, idx: '0, pdst: ext_p});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic          v;
        logic [PW-1:0] p;
        logic [IW-1:0] ix;
        int            hit;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       begin v = issue_valid;    p = issue_pdst;    ix = issue_slot_idx; end
                    1:       begin v = wakeup_0_valid; p = wakeup_0_pdst; ix = '0; end
                    default: begin v = wakeup_1_valid; p = wakeup_1_pdst; ix = '0; end
                endcase
                hit = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].kind == k && sb[i].cyc == cyc) hit = i;
                end
                if (v) begin
                    n_tests++;
                    if (hit < 0) begin
                        n_fail++;
                        $display("FAIL %s unexpected at cycle %0d: pdst=%0h idx=%0d", kname[k], cyc, p, ix);
                    end else begin
                        if (p !== sb[hit].pdst || ix !== sb[hit].idx) begin
                            n_fail++;
                            $display("FAIL %s data at cycle %0d: pdst=%0h idx=%0d expected pdst=%0h idx=%0d",
                                     kname[k], cyc, p, ix, sb[hit].pdst, sb[hit].idx);
                        end
                        sb.delete(hit);
                    end
                end else if (hit >= 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s missing at cycle %0d: valid=0 expected pdst=%0h", kname[k], cyc, sb[hit].pdst);
                    sb.delete(hit);
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s stale entry for cycle %0d seen at %0d", kname[sb[i].kind], sb[i].cyc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        req = '0; wrd = '0; fu_ready = 1'b1; kill = 1'b0; ext_v = 1'b0; ext_p = '0;
        for (int i = 0; i < N; i++) begin
            pdst_a[i] = PW'(8'h40 + i);
            lat_a[i]  = 3'd1;
        end
        req = 8'hFF;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",    32'(slot_grant), 32'h0);
        chk("rst_issue_v",  32'(issue_valid), 32'h0);
        chk("rst_issue_p",  32'(issue_pdst), 32'h0);
        chk("rst_wk0_v",    32'(wakeup_0_valid), 32'h0);
        chk("rst_wk1_v",    32'(wakeup_1_valid), 32'h0);

        // T1: fill the schedule, then reset mid-cycle
        reset = 1'b1;
        req = 8'h01; set_slot(0, 7'h11, 3'd3, 1'b1); step(8'h01, "t1_g0");
        req = 8'h02; set_slot(1, 7'h12, 3'd3, 1'b1); step(8'h02, "t1_g1");
        req = 8'h04; set_slot(2, 7'h13, 3'd1, 1'b0); step(8'h04, "t1_g2");
        req = 8'h00;
        #1;
        chk("t1_pre_wk0_v", 32'(wakeup_0_valid), 32'h1);
        chk("t1_pre_iss_v", 32'(issue_valid), 32'h1);
        req = 8'hFF; wrd = '0;
        reset = 1'b0;
        #1;
        chk("t1_rst_grant", 32'(slot_grant), 32'h0);
        chk("t1_rst_wk0_v", 32'(wakeup_0_valid), 32'h0);
        chk("t1_rst_iss_v", 32'(issue_valid), 32'h0);
        sb.delete();
        exp_grants = 0;
        exp_conf = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(8'h01, "t1_first_grant");

        // T2: round-robin between slots 0 and 7 (rr_ptr now 1)
        set_slot(0, 7'h01, 3'd1, 1'b1); set_slot(7, 7'h07, 3'd1, 1'b1);
        req = 8'h81;
        step(8'h80, "t2_a"); step(8'h01, "t2_b"); step(8'h80, "t2_c"); step(8'h01, "t2_d");

        // T3: latency 3 on slot 3
        req = 8'h08; set_slot(3, 7'h15, 3'd3, 1'b1); step(8'h08, "t3_grant");
        req = 8'h00;
        repeat (4) step(8'h00, "t3_idle");

        // T4: writeback-port conflict withholds the grant for one cycle
        req = 8'h10; set_slot(4, 7'h24, 3'd3, 1'b1); step(8'h10, "t4_grant");
        req = 8'h04; set_slot(2, 7'h22, 3'd2, 1'b1); step(8'h00, "t4_conflict");
        step(8'h04, "t4_retry");
        req = 8'h00;
        repeat (4) step(8'h00, "t4_idle");

        // T5: kill with three wakeups in flight
        set_slot(3, 7'h31, 3'd4, 1'b1); set_slot(4, 7'h32, 3'd4, 1'b1); set_slot(5, 7'h33, 3'd4, 1'b1);
        req = 8'h08; step(8'h08, "t5_g3");
        req = 8'h10; step(8'h10, "t5_g4");
        req = 8'h20; step(8'h20, "t5_g5");
        req = 8'h38; kill = 1'b1; ext_v = 1'b1; ext_p = 7'h3C;
        step(8'h00, "t5_kill");
        kill = 1'b0; ext_v = 1'b0; req = 8'h00;
        repeat (3) step(8'h00, "t5_idle");
        set_slot(0, 7'h0E, 3'd1, 1'b1); req = 8'h01;
        step(8'h01, "t5_regrant");
        req = 8'h00;
        repeat (2) step(8'h00, "t5_idle2");

        // T6: FU stall with external writeback
        fu_ready = 1'b0; req = 8'hFF; ext_v = 1'b1; ext_p = 7'h2A;
        step(8'h00, "t6_stall");
        fu_ready = 1'b1; ext_v = 1'b0; req = 8'h00;
        repeat (3) step(8'h00, "t6_idle");

        chk("sb_drained", 32'(sb.size()), 32'h0);
`ifdef ISSUE_SELECT_PERF_CNT_EN
        chk("perf_grant_cnt",    perf_grant_cnt, 32'(exp_grants));
        chk("perf_conflict_cnt", perf_conflict_cnt, 32'(exp_conf));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
